// File: rtl/regf_wb_arb.sv
// regf_wb_arb: write-back arbiter and busy scoreboard for the single write
// port of the integer register file.
//  - Round-robin arbitration between NREQ write-back sources (0=ALU, 1=LSU, 2=CSR).
//  - One-cycle registered write stage onto the regf write port.
//  - Per-register busy scoreboard with set-at-issue / clear-at-write.
// Optional feature macro: WB_BYPASS_EN adds write-stage forwarding ports
// (o_rs1_fwd/o_rs2_fwd and their data) and masks o_rsX_busy with them.
//
// Handshake: requester i holds i_req_valid[i] with stable addr/data until it
// sees o_req_ready[i]; a transfer happens on the rising edge where both are
// high. o_req_ready is combinational, one-hot or zero, and never asserts
// without the matching valid.
module regf_wb_arb #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREG = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]    o_req_ready,
  input  logic               i_iss_valid,
  input  logic [AW-1:0]      i_iss_rd,
  input  logic [AW-1:0]      i_rs1_addr,
  input  logic [AW-1:0]      i_rs2_addr,
  output logic               o_rs1_busy,
  output logic               o_rs2_busy,
  output logic               o_rd_busy,
  output logic               o_regf_wen,
  output logic [AW-1:0]      o_regf_waddr,
  output logic [DW-1:0]      o_regf_wdata,
  output logic               o_sb_err
`ifdef WB_BYPASS_EN
  ,
  output logic               o_rs1_fwd,
  output logic               o_rs2_fwd,
  output logic [DW-1:0]      o_rs1_fwd_data,
  output logic [DW-1:0]      o_rs2_fwd_data
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NA = 1 << AW;

  logic [PW-1:0]   ptr;
  logic [NREG-1:0] busy;
  logic [PW:0]     cand;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NA-1:0]   busy_ext;
  logic            iss_err;
  logic            wr_err;
  logic            rs1_raw;
  logic            rs2_raw;

  // A writable architectural register: not x0 and below NREG.
  function automatic logic live_addr(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < (AW + 1)'(NREG));
  endfunction

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    o_req_ready = '0;
    gnt_any     = 1'b0;
    gnt_idx     = '0;
    cand        = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = {1'b0, ptr} + (PW + 1)'(j);
      if (cand >= (PW + 1)'(NREQ)) cand = cand - (PW + 1)'(NREQ);
      if (!gnt_any && i_req_valid[cand[PW-1:0]]) begin
        gnt_any                     = 1'b1;
        gnt_idx                     = cand[PW-1:0];
        o_req_ready[cand[PW-1:0]]   = 1'b1;
      end
    end
    gnt_addr = i_req_addr[gnt_idx*AW +: AW];
    gnt_data = i_req_data[gnt_idx*DW +: DW];
  end

  // Scoreboard set/clear decode, lookups and protocol-error detection.
  always_comb begin
    set_vec  = '0;
    clr_vec  = '0;
    for (int r = 1; r < NREG; r++) begin
      set_vec[r] = i_iss_valid && (i_iss_rd == AW'(r));
      clr_vec[r] = o_regf_wen && (o_regf_waddr == AW'(r));
    end
    // Widen to the full address space so out-of-range lookups read 0.
    busy_ext             = '0;
    busy_ext[NREG-1:0]   = busy;
    iss_err  = i_iss_valid && busy_ext[i_iss_rd] &&
               !(o_regf_wen && (o_regf_waddr == i_iss_rd));
    wr_err   = gnt_any && live_addr(gnt_addr) && !busy_ext[gnt_addr];
    rs1_raw  = busy_ext[i_rs1_addr];
    rs2_raw  = busy_ext[i_rs2_addr];
    o_rd_busy = busy_ext[i_iss_rd];
  end

`ifdef WB_BYPASS_EN
  // Forward the value sitting in the write stage; it clears busy next edge.
  always_comb begin
    o_rs1_fwd      = o_regf_wen && (o_regf_waddr == i_rs1_addr) && (i_rs1_addr != '0);
    o_rs2_fwd      = o_regf_wen && (o_regf_waddr == i_rs2_addr) && (i_rs2_addr != '0);
    o_rs1_fwd_data = o_regf_wdata;
    o_rs2_fwd_data = o_regf_wdata;
    o_rs1_busy     = rs1_raw && !o_rs1_fwd;
    o_rs2_busy     = rs2_raw && !o_rs2_fwd;
  end
`else
  // Without forwarding, consumers see the raw busy bits.
  always_comb begin
    o_rs1_busy = rs1_raw;
    o_rs2_busy = rs2_raw;
  end
`endif

  // Pointer advance, write stage, busy update (set beats clear) and sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr          <= '0;
      busy         <= '0;
      o_regf_wen   <= 1'b0;
      o_regf_waddr <= '0;
      o_regf_wdata <= '0;
      o_sb_err     <= 1'b0;
    end else begin
      o_regf_wen <= gnt_any && live_addr(gnt_addr);
      if (gnt_any) begin
        ptr          <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        o_regf_waddr <= gnt_addr;
        o_regf_wdata <= gnt_data;
      end
      busy <= (busy & ~clr_vec) | set_vec;
      if (iss_err || wr_err) o_sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regf_wb_arb.sv
// tb_regf_wb_arb: directed bench for regf_wb_arb (NREQ=3, AW=5, DW=32, NREG=16).
// Inputs change 1 time unit after a rising edge; outputs are read 1 unit later.
module tb_regf_wb_arb;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 16;

  logic               i_clk;
  logic               i_rst_n;
  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ*AW-1:0] i_req_addr;
  logic [NREQ*DW-1:0] i_req_data;
  logic [NREQ-1:0]    o_req_ready;
  logic               i_iss_valid;
  logic [AW-1:0]      i_iss_rd;
  logic [AW-1:0]      i_rs1_addr;
  logic [AW-1:0]      i_rs2_addr;
  logic               o_rs1_busy;
  logic               o_rs2_busy;
  logic               o_rd_busy;
  logic               o_regf_wen;
  logic [AW-1:0]      o_regf_waddr;
  logic [DW-1:0]      o_regf_wdata;
  logic               o_sb_err;
`ifdef WB_BYPASS_EN
  logic               o_rs1_fwd;
  logic               o_rs2_fwd;
  logic [DW-1:0]      o_rs1_fwd_data;
  logic [DW-1:0]      o_rs2_fwd_data;
`endif

  int tests_run;
  int tests_failed;

  regf_wb_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREG(NREG)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_req_data   (i_req_data),
    .o_req_ready  (o_req_ready),
    .i_iss_valid  (i_iss_valid),
    .i_iss_rd     (i_iss_rd),
    .i_rs1_addr   (i_rs1_addr),
    .i_rs2_addr   (i_rs2_addr),
    .o_rs1_busy   (o_rs1_busy),
    .o_rs2_busy   (o_rs2_busy),
    .o_rd_busy    (o_rd_busy),
    .o_regf_wen   (o_regf_wen),
    .o_regf_waddr (o_regf_waddr),
    .o_regf_wdata (o_regf_wdata),
    .o_sb_err     (o_sb_err)
`ifdef WB_BYPASS_EN
    ,
    .o_rs1_fwd      (o_rs1_fwd),
    .o_rs2_fwd      (o_rs2_fwd),
    .o_rs1_fwd_data (o_rs1_fwd_data),
    .o_rs2_fwd_data (o_rs2_fwd_data)
`endif
  );

  // Clock and watchdog
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req_valid = '0;
    i_req_addr  = '0;
    i_req_data  = '0;
    i_iss_valid = 1'b0;
    i_iss_rd    = '0;
    i_rs1_addr  = '0;
    i_rs2_addr  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    #1;
  endtask

  // Scenario tasks
  task automatic test_reset();
    do_reset();
    i_req_valid = '0;
    i_rs1_addr  = 5'd3;
    i_rs2_addr  = 5'd7;
    i_iss_rd    = 5'd9;
    #1;
    tests_run++;
    if (o_regf_wen !== 1'b0) begin tests_failed++; $display("FAIL reset_wen: got %b expected 0", o_regf_wen); end
    tests_run++;
    if (o_regf_waddr !== 5'd0) begin tests_failed++; $display("FAIL reset_waddr: got %0d expected 0", o_regf_waddr); end
    tests_run++;
    if (o_regf_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset_wdata: got %h expected 0", o_regf_wdata); end
    tests_run++;
    if (o_sb_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", o_sb_err); end
    tests_run++;
    if ({o_rs1_busy, o_rs2_busy, o_rd_busy} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 000", {o_rs1_busy, o_rs2_busy, o_rd_busy});
    end
    tests_run++;
    if (o_req_ready !== 3'b000) begin tests_failed++; $display("FAIL reset_ready: got %b expected 000", o_req_ready); end
  endtask

  task automatic test_single_write();
    logic exp_wstage_busy;
    do_reset();
    i_iss_valid = 1'b1;
    i_iss_rd    = 5'd5;
    #1;
    tests_run++;
    if (o_rd_busy !== 1'b0) begin tests_failed++; $display("FAIL t1_rd_busy_pre: got %b expected 0", o_rd_busy); end
    tick();
    i_iss_valid          = 1'b0;
    i_rs1_addr           = 5'd5;
    i_req_valid          = 3'b001;
    i_req_addr[0 +: AW]  = 5'd5;
    i_req_data[0 +: DW]  = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (o_rs1_busy !== 1'b1) begin tests_failed++; $display("FAIL t1_busy_set: got %b expected 1", o_rs1_busy); end
    tests_run++;
    if (o_req_ready !== 3'b001) begin tests_failed++; $display("FAIL t1_ready: got %b expected 001", o_req_ready); end
    tick();
    i_req_valid = '0;
    #1;
    tests_run++;
    if ({o_regf_wen, o_regf_waddr, o_regf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL t1_write: got wen=%b addr=%0d data=%h expected wen=1 addr=5 data=deadbeef",
               o_regf_wen, o_regf_waddr, o_regf_wdata);
    end
`ifdef WB_BYPASS_EN
    exp_wstage_busy = 1'b0;
`else
    exp_wstage_busy = 1'b1;
`endif
    tests_run++;
    if (o_rs1_busy !== exp_wstage_busy) begin
      tests_failed++; $display("FAIL t1_busy_wstage: got %b expected %b", o_rs1_busy, exp_wstage_busy);
    end
    tick();
    tests_run++;
    if ({o_regf_wen, o_rs1_busy, o_sb_err} !== 3'b000) begin
      tests_failed++; $display("FAIL t1_after: got wen,busy,err=%b expected 000", {o_regf_wen, o_rs1_busy, o_sb_err});
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rr [6];
    int         cnt [3];
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    cnt    = '{0, 0, 0};
    do_reset();
    i_req_valid = 3'b111;
    i_req_addr  = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      tests_run++;
      if (o_req_ready !== exp_rr[c]) begin
        tests_failed++; $display("FAIL t2_grant_%0d: got %b expected %b", c, o_req_ready, exp_rr[c]);
      end
      for (int i = 0; i < 3; i++) if (o_req_ready[i]) cnt[i]++;
      tick();
    end
    i_req_valid = '0;
    #1;
    tests_run++;
    if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2) begin
      tests_failed++; $display("FAIL t2_counts: got %0d/%0d/%0d expected 2/2/2", cnt[0], cnt[1], cnt[2]);
    end
    tests_run++;
    if ({o_regf_wen, o_sb_err} !== 2'b00) begin
      tests_failed++; $display("FAIL t2_x0_writes: got wen,err=%b expected 00", {o_regf_wen, o_sb_err});
    end
  endtask

  task automatic test_x0_out_of_range();
    // Pointer is 0 here after six grants ending on requester 2.
    i_iss_valid = 1'b1;
    i_iss_rd    = 5'd4;
    tick();
    i_iss_valid           = 1'b0;
    i_rs1_addr            = 5'd4;
    i_req_valid           = 3'b010;
    i_req_addr[AW +: AW]  = 5'd0;
    i_req_data[DW +: DW]  = 32'h11111111;
    #1;
    tests_run++;
    if (o_req_ready !== 3'b010) begin tests_failed++; $display("FAIL t3_ready_x0: got %b expected 010", o_req_ready); end
    tick();
    i_req_addr[AW +: AW] = 5'd20;
    #1;
    tests_run++;
    if (o_req_ready !== 3'b010) begin tests_failed++; $display("FAIL t3_ready_oor: got %b expected 010", o_req_ready); end
    tests_run++;
    if (o_regf_wen !== 1'b0) begin tests_failed++; $display("FAIL t3_wen_x0: got %b expected 0", o_regf_wen); end
    tick();
    i_req_valid = '0;
    #1;
    tests_run++;
    if (o_regf_wen !== 1'b0) begin tests_failed++; $display("FAIL t3_wen_oor: got %b expected 0", o_regf_wen); end
    tick();
    tests_run++;
    if ({o_rs1_busy, o_sb_err} !== 2'b10) begin
      tests_failed++; $display("FAIL t3_busy_err: got busy,err=%b expected 10", {o_rs1_busy, o_sb_err});
    end
  endtask

  task automatic test_same_edge();
    // Pointer is 2 here; requester 0 alone still wins by wrapping.
    i_iss_valid = 1'b1;
    i_iss_rd    = 5'd7;
    tick();
    i_iss_valid          = 1'b0;
    i_rs1_addr           = 5'd7;
    i_req_valid          = 3'b001;
    i_req_addr[0 +: AW]  = 5'd7;
    i_req_data[0 +: DW]  = 32'h00000077;
    #1;
    tests_run++;
    if (o_req_ready !== 3'b001) begin tests_failed++; $display("FAIL t4_ready: got %b expected 001", o_req_ready); end
    tick();
    i_req_valid = '0;
    i_iss_valid = 1'b1;
    i_iss_rd    = 5'd7;
    #1;
    tests_run++;
    if ({o_regf_wen, o_regf_waddr} !== {1'b1, 5'd7}) begin
      tests_failed++; $display("FAIL t4_wstage: got wen=%b addr=%0d expected wen=1 addr=7", o_regf_wen, o_regf_waddr);
    end
    tick();
    i_iss_valid = 1'b0;
    #1;
    tests_run++;
    if ({o_rs1_busy, o_sb_err} !== 2'b10) begin
      tests_failed++; $display("FAIL t4_set_wins: got busy,err=%b expected 10", {o_rs1_busy, o_sb_err});
    end
    i_iss_valid = 1'b1;
    i_iss_rd    = 5'd7;
    #1;
    tests_run++;
    if (o_rd_busy !== 1'b1) begin tests_failed++; $display("FAIL t4_waw_rd_busy: got %b expected 1", o_rd_busy); end
    tick();
    i_iss_valid = 1'b0;
    #1;
    tests_run++;
    if (o_sb_err !== 1'b1) begin tests_failed++; $display("FAIL t4_waw_err: got %b expected 1", o_sb_err); end
    tick();
    tests_run++;
    if (o_sb_err !== 1'b1) begin tests_failed++; $display("FAIL t4_err_sticky: got %b expected 1", o_sb_err); end
  endtask

  task automatic test_unowned_write();
    do_reset();
    tests_run++;
    if (o_sb_err !== 1'b0) begin tests_failed++; $display("FAIL err_cleared: got %b expected 0", o_sb_err); end
    i_req_valid            = 3'b100;
    i_req_addr[2*AW +: AW] = 5'd3;
    i_req_data[2*DW +: DW] = 32'hCAFE0003;
    #1;
    tests_run++;
    if (o_req_ready !== 3'b100) begin tests_failed++; $display("FAIL unowned_ready: got %b expected 100", o_req_ready); end
    tick();
    i_req_valid = '0;
    #1;
    tests_run++;
    if ({o_regf_wen, o_regf_waddr, o_regf_wdata, o_sb_err} !== {1'b1, 5'd3, 32'hCAFE0003, 1'b1}) begin
      tests_failed++;
      $display("FAIL unowned_write: got wen=%b addr=%0d data=%h err=%b expected 1/3/cafe0003/1",
               o_regf_wen, o_regf_waddr, o_regf_wdata, o_sb_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    i_iss_valid = 1'b1;
    i_iss_rd    = 5'd3;
    i_rs1_addr  = 5'd3;
    tick();
    i_iss_valid          = 1'b0;
    i_req_valid          = 3'b001;
    i_req_addr[0 +: AW]  = 5'd3;
    i_req_data[0 +: DW]  = 32'hAAAA5555;
    tick();
    i_req_valid = '0;
    #1;
    tests_run++;
    if ({o_regf_wen, o_rs1_busy} !== 2'b11 && {o_regf_wen, o_rs1_busy} !== 2'b10) begin
      tests_failed++; $display("FAIL t5_pre: got wen,busy=%b expected wen=1", {o_regf_wen, o_rs1_busy});
    end
    #1;
    i_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_regf_wen, o_regf_waddr, o_regf_wdata, o_rs1_busy, o_sb_err} !== {1'b1 ^ 1'b1, 5'd0, 32'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL t5_async: got wen=%b addr=%0d data=%h busy=%b err=%b expected all 0",
               o_regf_wen, o_regf_waddr, o_regf_wdata, o_rs1_busy, o_sb_err);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
    tests_run++;
    if ({o_regf_wen, o_rs1_busy} !== 2'b00) begin
      tests_failed++; $display("FAIL t5_after: got wen,busy=%b expected 00", {o_regf_wen, o_rs1_busy});
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    i_iss_valid = 1'b1;
    i_iss_rd    = 5'd9;
    tick();
    i_iss_valid            = 1'b0;
    i_rs2_addr             = 5'd9;
    i_rs1_addr             = 5'd0;
    i_req_valid            = 3'b010;
    i_req_addr[AW +: AW]   = 5'd9;
    i_req_data[DW +: DW]   = 32'h12345678;
    tick();
    i_req_valid = '0;
    #1;
    tests_run++;
    if ({o_rs2_fwd, o_rs2_fwd_data, o_rs2_busy, o_rs1_fwd} !== {1'b1, 32'h12345678, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL t6_fwd: got fwd=%b data=%h busy=%b rs1_fwd=%b expected 1/12345678/0/0",
               o_rs2_fwd, o_rs2_fwd_data, o_rs2_busy, o_rs1_fwd);
    end
  endtask
`endif

  // Sequencer and final report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_rst_n      = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_x0_out_of_range();
    test_same_edge();
    test_unowned_write();
    test_async_reset();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
